// File: rtl/xsm_frame_assembler.sv
// Assembles round-robin channel samples into double-buffered, timestamped frames streamed as 16-bit words.
// Latency: last channel sample accepted in cycle N -> buffer full in N+1 -> first word (w0) valid in N+2.
// Backpressure: out_ready stalls only the word stream; the capture side is never stalled (overflowing frames are dropped and counted).
module xsm_frame_assembler #(
    parameter int          NUM_CH    = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic [3:0]  channel_id,
    input  logic [47:0] mono_counter,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [7:0]  frame_seq,
    output logic [15:0] seq_err_cnt,
    output logic [15:0] overflow_cnt
);

    localparam int FRAME_LEN = NUM_CH + 4;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0]       LAST_CH  = 4'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {W_HUNT, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_SEND} rd_state_t;

    typedef struct packed {
        logic [7:0]  seq;
        logic [47:0] ts;
    } hdr_t;

    wr_state_t wr_state, wr_nxt;
    rd_state_t rd_state, rd_nxt;

    logic [3:0]       expected, exp_nxt;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       full;
    logic [IDX_W-1:0] idx;

    logic store, latch_ts, complete, seq_err, drop, last_hs;

    hdr_t        hdr [2];
    logic [15:0] smp [2][NUM_CH];

    // ---------------- write side ----------------
    always_comb begin
        wr_nxt   = wr_state;
        exp_nxt  = expected;
        store    = 1'b0;
        latch_ts = 1'b0;
        complete = 1'b0;
        seq_err  = 1'b0;
        drop     = 1'b0;
        if (sample_valid) begin
            case (wr_state)
                W_HUNT: begin
                    if (channel_id == 4'd0) begin
                        if (full[wr_ptr]) begin
                            drop = 1'b1;
                        end else begin
                            store    = 1'b1;
                            latch_ts = 1'b1;
                            if (NUM_CH == 1) begin
                                complete = 1'b1;
                            end else begin
                                wr_nxt  = W_FILL;
                                exp_nxt = 4'd1;
                            end
                        end
                    end
                end
                W_FILL: begin
                    if (channel_id == expected) begin
                        store = 1'b1;
                        if (expected == LAST_CH) begin
                            complete = 1'b1;
                            wr_nxt   = W_HUNT;
                        end else begin
                            exp_nxt = expected + 4'd1;
                        end
                    end else begin
                        seq_err = 1'b1;
                        // A stray ch0 restarts the sweep in place; anything else waits for the next ch0.
                        if (channel_id == 4'd0) begin
                            store    = 1'b1;
                            latch_ts = 1'b1;
                            exp_nxt  = 4'd1;
                        end else begin
                            wr_nxt = W_HUNT;
                        end
                    end
                end
                default: wr_nxt = W_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state     <= W_HUNT;
            expected     <= 4'd0;
            wr_ptr       <= 1'b0;
            frame_seq    <= 8'd0;
            seq_err_cnt  <= 16'd0;
            overflow_cnt <= 16'd0;
        end else begin
            wr_state <= wr_nxt;
            expected <= exp_nxt;
            if (complete)
                wr_ptr <= ~wr_ptr;
            if (complete || drop)
                frame_seq <= frame_seq + 8'd1;
            if (seq_err && (seq_err_cnt != 16'hFFFF))
                seq_err_cnt <= seq_err_cnt + 16'd1;
            if (drop && (overflow_cnt != 16'hFFFF))
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    // Frame storage carries no reset; it is only read behind a set full flag.
    always_ff @(posedge clk) begin
        if (store)
            smp[wr_ptr][channel_id[CH_W-1:0]] <= sample_data;
        if (latch_ts)
            hdr[wr_ptr].ts <= mono_counter;
        if (complete)
            hdr[wr_ptr].seq <= frame_seq;
    end

    // Set and clear never hit the same buffer: set needs it empty, clear needs it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            full <= 2'b00;
        else
            full <= (full | {complete & wr_ptr, complete & ~wr_ptr})
                          & ~{last_hs & rd_ptr, last_hs & ~rd_ptr};
    end

    // ---------------- read side ----------------
    logic [15:0]      word;
    logic [IDX_W-1:0] sidx_full;
    hdr_t             rhdr;

    always_comb begin
        rhdr      = hdr[rd_ptr];
        sidx_full = idx - IDX_W'(4);
        if (idx == IDX_W'(0))
            word = {SYNC_BYTE, rhdr.seq};
        else if (idx == IDX_W'(1))
            word = rhdr.ts[47:32];
        else if (idx == IDX_W'(2))
            word = rhdr.ts[31:16];
        else if (idx == IDX_W'(3))
            word = rhdr.ts[15:0];
        else
            word = smp[rd_ptr][sidx_full[CH_W-1:0]];
    end

    always_comb begin
        rd_nxt    = rd_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 16'd0;
        last_hs   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (full[rd_ptr])
                    rd_nxt = R_SEND;
            end
            R_SEND: begin
                out_valid = 1'b1;
                out_data  = word;
                out_last  = (idx == LAST_IDX);
                if (out_ready && (idx == LAST_IDX)) begin
                    last_hs = 1'b1;
                    rd_nxt  = R_IDLE;
                end
            end
            default: rd_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_ptr   <= 1'b0;
            idx      <= '0;
        end else begin
            rd_state <= rd_nxt;
            if (rd_state == R_IDLE)
                idx <= '0;
            else if (out_ready) begin
                if (last_hs)
                    rd_ptr <= ~rd_ptr;
                else
                    idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xsm_frame_assembler.sv
// Scoreboard bench for xsm_frame_assembler: expected words are queued as sweeps are driven and popped on each handshake.
module tb_xsm_frame_assembler;

    localparam int NUM_CH = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = 16'd0;
    logic [3:0]  channel_id = 4'd0;
    logic [47:0] mono_counter = 48'd0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [7:0]  frame_seq;
    logic [15:0] seq_err_cnt;
    logic [15:0] overflow_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [16:0] sb_q[$];
    logic [16:0] exp_w;
    logic        bp_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_obs = 18'd0;

    xsm_frame_assembler #(.NUM_CH(NUM_CH), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .channel_id   (channel_id),
        .mono_counter (mono_counter),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .frame_seq    (frame_seq),
        .seq_err_cnt  (seq_err_cnt),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bp_en) begin
            #1 out_ready = ~out_ready;
        end
    end

    // Output monitor: stall stability plus in-order scoreboard compare.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if ({out_valid, out_last, out_data} !== prev_obs) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h required %h", {out_valid, out_last, out_data}, prev_obs);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got last=%b data=%h required no word", out_last, out_data);
                end else begin
                    exp_w = sb_q.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL word: got last=%b data=%h required last=%b data=%h",
                                 out_last, out_data, exp_w[16], exp_w[15:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = {out_valid, out_last, out_data};
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ch, input logic [15:0] d, input logic [47:0] ts);
        sample_valid = 1'b1;
        channel_id   = ch;
        sample_data  = d;
        mono_counter = ts;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        mono_counter = ts + 48'd99;
    endtask

    task automatic sweep(input logic [47:0] ts, input logic [15:0] base);
        for (int c = 0; c < NUM_CH; c++)
            drive(4'(c), base + 16'(c), ts + 48'(c * 3));
    endtask

    task automatic push_frame(input logic [7:0] seq, input logic [47:0] ts, input logic [15:0] base);
        sb_q.push_back({1'b0, 8'hA5, seq});
        sb_q.push_back({1'b0, ts[47:32]});
        sb_q.push_back({1'b0, ts[31:16]});
        sb_q.push_back({1'b0, ts[15:0]});
        for (int c = 0; c < NUM_CH; c++)
            sb_q.push_back({(c == NUM_CH - 1), 16'(base + 16'(c))});
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        while (sb_q.size() != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d words pending required 0", name, sb_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        sample_valid = 1'b0;
        bp_en        = 1'b0;
        out_ready    = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sync();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_last, out_data} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, out_last, out_data});
        end
        n_checks++;
        if (frame_seq !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_frame_seq: got %h required 00", frame_seq);
        end
        n_checks++;
        if (seq_err_cnt !== 16'd0 || overflow_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h required 0/0", seq_err_cnt, overflow_cnt);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_ramp();
        apply_reset();
        out_ready = 1'b1;
        push_frame(8'h00, 48'h0000_1234_5678, 16'h1000);
        sweep(48'h0000_1234_5678, 16'h1000);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_latency_n1: got out_valid=%b required 0", out_valid);
        end
        sync();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA500) begin
            n_fail++;
            $display("FAIL ramp_latency_n2: got valid=%b data=%h required 1/A500", out_valid, out_data);
        end
        wait_drain("ramp");
        n_checks++;
        if (frame_seq !== 8'd1) begin
            n_fail++;
            $display("FAIL ramp_frame_seq: got %h required 01", frame_seq);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        push_frame(8'h00, 48'h0000_0000_0100, 16'h1100);
        push_frame(8'h01, 48'h0000_0000_0200, 16'h1200);
        sweep(48'h0000_0000_0100, 16'h1100);
        sweep(48'h0000_0000_0200, 16'h1200);
        repeat (4) sync();
        n_checks++;
        if (out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_last: got out_last=%b required 1", out_last);
        end
        sync();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got out_valid=%b required 0", out_valid);
        end
        sync();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA501) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%b data=%h required 1/A501", out_valid, out_data);
        end
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b1;
        bp_en     = 1'b1;
        push_frame(8'h00, 48'h0000_1234_5678, 16'h1000);
        sweep(48'h0000_1234_5678, 16'h1000);
        wait_drain("backpressure");
        bp_en     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_seq_fault();
        apply_reset();
        out_ready = 1'b1;
        drive(4'd0, 16'hDEAD, 48'h0000_0000_0AAA);
        drive(4'd1, 16'hDEAD, 48'h0000_0000_0AAB);
        drive(4'd3, 16'hDEAD, 48'h0000_0000_0AAC);
        n_checks++;
        if (seq_err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL fault_count: got %h required 0001", seq_err_cnt);
        end
        drive(4'd5, 16'hBEEF, 48'h0000_0000_0AAD);
        n_checks++;
        if (seq_err_cnt !== 16'd1 || frame_seq !== 8'd0) begin
            n_fail++;
            $display("FAIL fault_hunt_ignore: got err=%h seq=%h required 0001/00", seq_err_cnt, frame_seq);
        end
        push_frame(8'h00, 48'h0000_3333_0000, 16'h3000);
        sweep(48'h0000_3333_0000, 16'h3000);
        wait_drain("fault");

        apply_reset();
        out_ready = 1'b1;
        drive(4'd0, 16'hDEAD, 48'h0000_0000_AAAA);
        drive(4'd1, 16'hDEAD, 48'h0000_0000_AAAB);
        push_frame(8'h00, 48'h0000_0000_BBBB, 16'h3100);
        sweep(48'h0000_0000_BBBB, 16'h3100);
        n_checks++;
        if (seq_err_cnt !== 16'd1 || frame_seq !== 8'd1) begin
            n_fail++;
            $display("FAIL restart_counts: got err=%h seq=%h required 0001/01", seq_err_cnt, frame_seq);
        end
        wait_drain("restart");
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        push_frame(8'h00, 48'h0000_0000_4000, 16'h4000);
        push_frame(8'h01, 48'h0000_0000_4100, 16'h4100);
        sweep(48'h0000_0000_4000, 16'h4000);
        sweep(48'h0000_0000_4100, 16'h4100);
        sweep(48'h0000_0000_4200, 16'h4200);
        n_checks++;
        if (overflow_cnt !== 16'd1 || frame_seq !== 8'd3) begin
            n_fail++;
            $display("FAIL overflow_counts: got ovf=%h seq=%h required 0001/03", overflow_cnt, frame_seq);
        end
        n_checks++;
        if (seq_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL overflow_ignore: got err=%h required 0000", seq_err_cnt);
        end
        out_ready = 1'b1;
        wait_drain("overflow");
        repeat (20) @(negedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push_frame(8'(i), 48'(i) * 48'h0001_0001_0001, 16'(i << 4));
            sync();
            sweep(48'(i) * 48'h0001_0001_0001, 16'(i << 4));
            wait_drain("wrap");
        end
        n_checks++;
        if (frame_seq !== 8'd0 || overflow_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_seq: got seq=%h ovf=%h required 00/0000", frame_seq, overflow_cnt);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        sample_valid = 1'b1;
        channel_id   = 4'd0;
        sample_data  = 16'h0000;
        // First ch0 opens a frame; each further ch0 is a fault-and-restart.
        repeat (65537) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        n_checks++;
        if (seq_err_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL seq_err_saturate: got %h required FFFF", seq_err_cnt);
        end
    endtask

    task automatic test_reset_mid_send();
        int b = 0;
        apply_reset();
        out_ready = 1'b1;
        drive(4'd0, 16'hDEAD, 48'h0000_0000_0001);
        drive(4'd2, 16'hDEAD, 48'h0000_0000_0002);
        push_frame(8'h00, 48'h0000_0000_5555, 16'h5000);
        sweep(48'h0000_0000_5555, 16'h5000);
        while (!out_valid && b < 20) begin
            sync();
            b++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midsend_start: got out_valid=%b required 1", out_valid);
        end
        repeat (4) sync();
        n_checks++;
        if (out_data !== 16'h5000) begin
            n_fail++;
            $display("FAIL midsend_word5: got %h required 5000", out_data);
        end
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        n_checks++;
        if ({out_valid, out_last, out_data} !== 18'd0) begin
            n_fail++;
            $display("FAIL midsend_outputs: got %h required 0", {out_valid, out_last, out_data});
        end
        n_checks++;
        if (frame_seq !== 8'd0 || seq_err_cnt !== 16'd0 || overflow_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midsend_counters: got seq=%h err=%h ovf=%h required 0", frame_seq, seq_err_cnt, overflow_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sync();
        push_frame(8'h00, 48'h0000_0000_6666, 16'h6000);
        sweep(48'h0000_0000_6666, 16'h6000);
        wait_drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_seq_fault();
        test_overflow();
        test_wrap();
        test_saturation();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
